// File: rtl/motion_detector_if.sv
// Video-side signal bundle for motion_detector: the pixel stream and control inputs
// from the subtraction stage, and the per-pixel mask and per-frame results going out.
interface motion_detector_if #(
    parameter int XW = 9,
    parameter int YW = 8,
    parameter int CW = 17
);
    logic          vtcvsync;
    logic          vtcvde;
    logic [4:0]    diff_in;
    logic [4:0]    threshold;
    logic [CW-1:0] min_count;

    logic          motion_pix;
    logic          mask_valid;
    logic          frame_done;
    logic          frame_err;
    logic [CW-1:0] motion_count;
    logic          motion_detected;
    logic [XW-1:0] x_min;
    logic [XW-1:0] x_max;
    logic [YW-1:0] y_min;
    logic [YW-1:0] y_max;
    logic          bbox_valid;

    modport master (
        output vtcvsync, vtcvde, diff_in, threshold, min_count,
        input  motion_pix, mask_valid, frame_done, frame_err, motion_count,
               motion_detected, x_min, x_max, y_min, y_max, bbox_valid
    );

    modport slave (
        input  vtcvsync, vtcvde, diff_in, threshold, min_count,
        output motion_pix, mask_valid, frame_done, frame_err, motion_count,
               motion_detected, x_min, x_max, y_min, y_max, bbox_valid
    );
endinterface

// File: rtl/motion_detector.sv
// Thresholds the difference stream into a motion mask and accumulates per-frame
// motion count and bounding box, published once per completed frame.
module motion_detector #(
    parameter int H_PIX   = 320,
    parameter int V_LINES = 240,
    parameter int XW      = 9,
    parameter int YW      = 8,
    parameter int CW      = 17
) (
    input  logic               pclk,
    input  logic               reset,
    motion_detector_if.slave   vid
);
    typedef enum logic [1:0] {WAIT_SYNC, ACTIVE, REPORT} state_e;

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic [XW-1:0] x_min;
        logic [XW-1:0] x_max;
        logic [YW-1:0] y_min;
        logic [YW-1:0] y_max;
    } stats_t;

    // x runs one bit wider than a column index so it can park at H_PIX on overlong lines
    localparam logic [XW:0]   X_SAT  = (XW+1)'(H_PIX);
    localparam logic [XW-1:0] X_LAST = XW'(H_PIX - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_LINES - 1);
    localparam stats_t WORK_INIT = '{cnt: '0, x_min: X_LAST, x_max: '0, y_min: Y_LAST, y_max: '0};

    state_e        state_q, state_d;
    logic [XW:0]   x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    stats_t        work_q, work_d;
    stats_t        pub_q, pub_d;
    logic          det_q, det_d;
    logic          bbox_q, bbox_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          pend_q, pend_d;
    logic          de_q;
    logic          mpix_q;

    logic          is_motion;
    logic [XW-1:0] x_col;

    assign is_motion = vid.vtcvde && (vid.diff_in > vid.threshold);
    assign x_col     = x_q[XW-1:0];

    always_comb begin
        // NOTE: every next-state signal gets a default first so no branch infers a latch.
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        work_d  = work_q;
        pub_d   = pub_q;
        det_d   = det_q;
        bbox_d  = bbox_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        pend_d  = pend_q;

        case (state_q)
            WAIT_SYNC: begin
                if (vid.vtcvsync || pend_q) begin
                    x_d     = '0;
                    y_d     = '0;
                    work_d  = WORK_INIT;
                    pend_d  = 1'b0;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (vid.vtcvsync) begin
                    // Early sync: drop the partial frame and start a fresh one in place
                    x_d    = '0;
                    y_d    = '0;
                    work_d = WORK_INIT;
                    err_d  = 1'b1;
                end else if (vid.vtcvde) begin
                    if (is_motion && (x_q < X_SAT)) begin
                        work_d.cnt   = work_q.cnt + 1'b1;
                        work_d.x_min = (x_col < work_q.x_min) ? x_col : work_q.x_min;
                        work_d.x_max = (x_col > work_q.x_max) ? x_col : work_q.x_max;
                        work_d.y_min = (y_q < work_q.y_min) ? y_q : work_q.y_min;
                        work_d.y_max = (y_q > work_q.y_max) ? y_q : work_q.y_max;
                    end
                    if (x_q != X_SAT) x_d = x_q + 1'b1;
                end else if (de_q) begin
                    x_d = '0;
                    y_d = y_q + 1'b1;
                    if (y_q == Y_LAST) state_d = REPORT;
                end
            end
            REPORT: begin
                pub_d   = (work_q.cnt != '0) ? work_q : '0;
                det_d   = (work_q.cnt >= vid.min_count);
                bbox_d  = (work_q.cnt != '0);
                done_d  = 1'b1;
                pend_d  = vid.vtcvsync;
                state_d = WAIT_SYNC;
            end
            default: state_d = WAIT_SYNC;
        endcase
    end

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            state_q <= WAIT_SYNC;
            x_q     <= '0;
            y_q     <= '0;
            work_q  <= '0;
            pub_q   <= '0;
            det_q   <= 1'b0;
            bbox_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
            de_q    <= 1'b0;
            mpix_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            work_q  <= work_d;
            pub_q   <= pub_d;
            det_q   <= det_d;
            bbox_q  <= bbox_d;
            done_q  <= done_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            de_q    <= vid.vtcvde;
            mpix_q  <= is_motion;
        end
    end

    assign vid.motion_pix      = mpix_q;
    assign vid.mask_valid      = de_q;
    assign vid.frame_done      = done_q;
    assign vid.frame_err       = err_q;
    assign vid.motion_count    = pub_q.cnt;
    assign vid.motion_detected = det_q;
    assign vid.x_min           = pub_q.x_min;
    assign vid.x_max           = pub_q.x_max;
    assign vid.y_min           = pub_q.y_min;
    assign vid.y_max           = pub_q.y_max;
    assign vid.bbox_valid      = bbox_q;
endmodule

// File: tb/tb_motion_detector.sv
// Scoreboard bench for motion_detector on a small 8x4 raster: frame-level reference
// model feeds expectation queues, a negedge monitor pops and compares.
module tb_motion_detector;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int XW = 3;
    localparam int YW = 2;
    localparam int CW = 6;
    localparam int MAXW = 12;

    typedef struct {
        int cnt;
        int det;
        int xmn;
        int xmx;
        int ymn;
        int ymx;
        int bv;
    } res_t;

    logic pclk;
    logic reset;

    motion_detector_if #(.XW(XW), .YW(YW), .CW(CW)) vif ();

    motion_detector #(.H_PIX(H), .V_LINES(V), .XW(XW), .YW(YW), .CW(CW)) dut (
        .pclk  (pclk),
        .reset (reset),
        .vid   (vif)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int   diff_arr [V][MAXW];
    int   line_len [V];
    int   thr;
    res_t frame_q[$];
    bit   mask_q[$];
    int   err_exp;
    res_t pub_exp;
    int   n_checks;
    int   n_fail;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: scan the raster as a picture, counting strictly-above-threshold pixels in range
    function automatic res_t model();
        res_t r;
        r = '{cnt: 0, det: 0, xmn: H - 1, xmx: 0, ymn: V - 1, ymx: 0, bv: 0};
        for (int y = 0; y < V; y++)
            for (int x = 0; x < line_len[y] && x < H; x++)
                if (diff_arr[y][x] > thr) begin
                    r.cnt++;
                    if (x < r.xmn) r.xmn = x;
                    if (x > r.xmx) r.xmx = x;
                    if (y < r.ymn) r.ymn = y;
                    if (y > r.ymx) r.ymx = y;
                end
        if (r.cnt == 0) begin
            r.xmn = 0; r.xmx = 0; r.ymn = 0; r.ymx = 0;
        end
        r.bv  = (r.cnt > 0) ? 1 : 0;
        r.det = (r.cnt >= int'(vif.min_count)) ? 1 : 0;
        return r;
    endfunction

    task automatic fill(input int val);
        for (int y = 0; y < V; y++) begin
            line_len[y] = H;
            for (int x = 0; x < MAXW; x++) diff_arr[y][x] = val;
        end
    endtask

    task automatic drive(input bit s, input bit de, input int d);
        @(posedge pclk);
        #1;
        vif.vtcvsync  = s;
        vif.vtcvde    = de;
        vif.diff_in   = 5'(d);
        vif.threshold = 5'(thr);
        if (de) mask_q.push_back(d > thr);
    endtask

    task automatic run_frame(input bit send_sync, input int abort_line,
                             input bit tail_sync, input bit expect_report);
        if (send_sync) begin
            drive(1'b1, 1'b0, 0);
            drive(1'b0, 1'b0, 0);
            drive(1'b0, 1'b0, 0);
        end
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < line_len[y]; x++) begin
                if (y == abort_line && x == line_len[y] / 2) begin
                    drive(1'b1, 1'b0, 0);
                    err_exp++;
                    drive(1'b0, 1'b0, 0);
                    drive(1'b0, 1'b0, 0);
                    return;
                end
                drive(1'b0, 1'b1, diff_arr[y][x]);
            end
            if (y == V - 1 && expect_report) frame_q.push_back(model());
            drive(1'b0, 1'b0, $urandom_range(0, 31));
            if (y == V - 1 && tail_sync) drive(1'b1, 1'b0, 0);
            drive(1'b0, 1'b0, $urandom_range(0, 31));
            drive(1'b0, 1'b0, $urandom_range(0, 31));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_motion_pix"}, int'(vif.motion_pix), 0);
        check({tag, "_mask_valid"}, int'(vif.mask_valid), 0);
        check({tag, "_frame_done"}, int'(vif.frame_done), 0);
        check({tag, "_frame_err"}, int'(vif.frame_err), 0);
        check({tag, "_count"}, int'(vif.motion_count), 0);
        check({tag, "_detected"}, int'(vif.motion_detected), 0);
        check({tag, "_box"}, int'({vif.x_min, vif.x_max, vif.y_min, vif.y_max}), 0);
        check({tag, "_bbox_valid"}, int'(vif.bbox_valid), 0);
    endtask

    // Monitor: decoupled from stimulus, compares whatever the DUT presents each cycle
    always @(negedge pclk) begin
        if (reset) begin
            if (vif.mask_valid) begin
                check("mask_expected", int'(mask_q.size() > 0), 1);
                if (mask_q.size() > 0) check("motion_pix", int'(vif.motion_pix), int'(mask_q.pop_front()));
            end else begin
                check("motion_pix_idle", int'(vif.motion_pix), 0);
            end
            if (vif.frame_done) begin
                check("frame_done_expected", int'(frame_q.size() > 0), 1);
                if (frame_q.size() > 0) pub_exp = frame_q.pop_front();
            end
            if (vif.frame_err) begin
                check("frame_err_expected", int'(err_exp > 0), 1);
                if (err_exp > 0) err_exp--;
            end
            check("motion_count", int'(vif.motion_count), pub_exp.cnt);
            check("motion_detected", int'(vif.motion_detected), pub_exp.det);
            check("x_min", int'(vif.x_min), pub_exp.xmn);
            check("x_max", int'(vif.x_max), pub_exp.xmx);
            check("y_min", int'(vif.y_min), pub_exp.ymn);
            check("y_max", int'(vif.y_max), pub_exp.ymx);
            check("bbox_valid", int'(vif.bbox_valid), pub_exp.bv);
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        err_exp  = 0;
        thr      = 10;
        pub_exp  = '{cnt: 0, det: 0, xmn: 0, xmx: 0, ymn: 0, ymx: 0, bv: 0};
        reset         = 1'b0;
        vif.vtcvsync  = 1'b0;
        vif.vtcvde    = 1'b0;
        vif.diff_in   = '0;
        vif.threshold = 5'(thr);
        vif.min_count = '0;
        #2;
        check_all_zero("reset_state");
        #21;
        reset = 1'b1;

        // Single motion pixel at (3,2)
        thr = 10; vif.min_count = 1;
        fill(0); diff_arr[2][3] = 11;
        run_frame(1'b1, -1, 1'b0, 1'b1);

        // diff equal to threshold is not motion
        fill(0); diff_arr[1][5] = 10; diff_arr[3][0] = 10;
        run_frame(1'b1, -1, 1'b0, 1'b1);

        // threshold 31 masks everything
        thr = 31; fill(31);
        run_frame(1'b1, -1, 1'b0, 1'b1);

        // Full frame of motion, decision threshold just above the count
        thr = 0; vif.min_count = 33; fill(31);
        run_frame(1'b1, -1, 1'b0, 1'b1);

        // Empty frame with min_count 0 still reports detected
        vif.min_count = 0; fill(0);
        run_frame(1'b1, -1, 1'b0, 1'b1);

        // Early sync mid-line 2, then the following complete frame
        thr = 10; vif.min_count = 2; fill(0);
        diff_arr[0][1] = 20; diff_arr[3][6] = 25; diff_arr[2][2] = 30;
        run_frame(1'b1, 2, 1'b0, 1'b0);
        diff_arr[1][4] = 12;
        run_frame(1'b0, -1, 1'b0, 1'b1);

        // Overlong line: motion at x=9 ignored, x=5 counted
        fill(0); line_len[1] = 10; diff_arr[1][9] = 31; diff_arr[1][5] = 31;
        run_frame(1'b1, -1, 1'b0, 1'b1);

        // Sync arriving during REPORT is held and starts the next frame
        fill(0); diff_arr[0][0] = 31;
        run_frame(1'b1, -1, 1'b1, 1'b1);
        fill(0); diff_arr[3][7] = 31; diff_arr[1][2] = 15;
        run_frame(1'b0, -1, 1'b0, 1'b1);

        // Randomised frames with ragged line lengths
        for (int f = 0; f < 8; f++) begin
            thr = $urandom_range(0, 31);
            vif.min_count = CW'($urandom_range(0, 20));
            for (int y = 0; y < V; y++) begin
                line_len[y] = $urandom_range(6, 10);
                for (int x = 0; x < MAXW; x++) diff_arr[y][x] = $urandom_range(0, 31);
            end
            run_frame(1'b1, -1, (f % 3) == 1, 1'b1);
            if ((f % 3) == 1) begin
                for (int y = 0; y < V; y++)
                    for (int x = 0; x < MAXW; x++) diff_arr[y][x] = $urandom_range(0, 31);
                run_frame(1'b0, -1, 1'b0, 1'b1);
            end
        end

        // Async reset mid-frame, between clock edges
        thr = 0; fill(20);
        drive(1'b1, 1'b0, 0);
        for (int i = 0; i < 12; i++) drive(1'b0, (i % 10) < 8, 20);
        @(posedge pclk);
        #3;
        reset = 1'b0;
        mask_q.delete();
        pub_exp = '{cnt: 0, det: 0, xmn: 0, xmx: 0, ymn: 0, ymx: 0, bv: 0};
        vif.vtcvde = 1'b0;
        vif.vtcvsync = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge pclk);
        #3;
        reset = 1'b1;

        // No sync after reset: frame is ignored; then a synced frame reports
        vif.min_count = 5;
        run_frame(1'b0, -1, 1'b0, 1'b0);
        fill(0); diff_arr[2][4] = 9; diff_arr[0][6] = 3;
        run_frame(1'b1, -1, 1'b0, 1'b1);

        repeat (10) drive(1'b0, 1'b0, 0);
        check("frames_pending", frame_q.size(), 0);
        check("masks_pending", mask_q.size(), 0);
        check("errs_pending", err_exp, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/motion_detector.md
# motion_detector

Downstream consumer of the background-subtraction stage. Takes the 5-bit absolute-difference pixel stream, thresholds each pixel into a motion mask, and accumulates per-frame statistics: motion-pixel count, bounding box, and a motion-detected decision. Per-frame results are held stable from one frame end to the next, for the display overlay and the control logic.

## Interface
Parameters:
- H_PIX, 320, active pixels per line
- V_LINES, 240, active lines per frame
- XW, 9, x-coordinate width (must hold H_PIX-1)
- YW, 8, y-coordinate width (must hold V_LINES-1)
- CW, 17, count width (must hold H_PIX*V_LINES)

Ports:
- pclk  in  1  pixel clock; the only clock
- reset  in  1  asynchronous, active-low reset
- vtcvsync  in  1  frame-start pulse, active-high, one or more cycles
- vtcvde  in  1  active-video enable; high while diff_in is valid
- diff_in  in  5  absolute difference pixel from the subtraction stage
- threshold  in  5  per-pixel motion threshold, quasi-static
- min_count  in  CW  motion-detected decision threshold, quasi-static
- motion_pix  out  1  registered per-pixel mask
- mask_valid  out  1  qualifies motion_pix
- frame_done  out  1  one-cycle pulse when frame results update
- frame_err  out  1  one-cycle pulse when a frame is aborted
- motion_count  out  CW  motion pixels in the last complete frame
- motion_detected  out  1  motion_count >= min_count, last frame
- x_min, x_max  out  XW  bounding box columns, last frame
- y_min, y_max  out  YW  bounding box rows, last frame
- bbox_valid  out  1  last frame had at least one motion pixel

## Operation
- Pixel test: a pixel is motion when diff_in > threshold (strictly greater, unsigned). With threshold=31, no pixel is ever motion.
- FSM states: WAIT_SYNC, ACTIVE, REPORT. The reset state is WAIT_SYNC.
- WAIT_SYNC: vtcvde is ignored. vtcvsync=1 clears the working registers (cnt, x, y, box) and moves to ACTIVE.
- ACTIVE, pixel handling: each cycle with vtcvde=1 is one pixel at (x,y).
  - When the pixel is motion and x < H_PIX, increment cnt and update the working box with min/max.
  - x increments and saturates at H_PIX. Pixels at x >= H_PIX are ignored for count and box.
- ACTIVE, end of line: a falling edge of vtcvde (previous sample 1, current 0) ends the line. x returns to 0 and y increments.
- ACTIVE, end of frame: when the line that ends has y = V_LINES-1, the next state is REPORT.
- ACTIVE, early sync: vtcvsync=1 in ACTIVE aborts the frame.
  - frame_err pulses.
  - The working registers clear and the FSM stays in ACTIVE, with the new frame starting.
  - Published outputs are unchanged.
- REPORT, one cycle:
  - Copy the working registers to the published outputs and pulse frame_done.
  - Go to WAIT_SYNC.
  - A vtcvsync arriving in REPORT is honoured the next cycle, not lost. It is held in a one-bit pending flag.
- Empty frame (cnt=0): bbox_valid=0, x_min=x_max=y_min=y_max=0, motion_detected = (min_count==0).
- Box initial values per frame: x_min=H_PIX-1, y_min=V_LINES-1, x_max=0, y_max=0. A box is published only when cnt>0.
- cnt cannot overflow given the CW rule. Lines beyond V_LINES cannot occur because the FSM leaves ACTIVE.
- Reset mid-frame: all state and outputs go to reset values immediately. The partial frame is discarded.

## Timing
- Reset values: all outputs 0.
- motion_pix and mask_valid: one cycle after the (vtcvde, diff_in) sample. mask_valid equals vtcvde delayed by one cycle. The mask is produced in every state, including WAIT_SYNC, and motion_pix=0 whenever mask_valid=0.
- frame_done, two cycles after sampling: if vtcvde is sampled 0 at edge N ending the last line, the FSM is in REPORT after edge N. At edge N+1 the results update and frame_done=1 for exactly one cycle.
- frame_err: high for the one cycle after the edge at which vtcvsync is sampled in ACTIVE.
- Published outputs are constant between frame_done pulses.
- threshold and min_count are sampled per pixel and at REPORT respectively. Changes mid-frame take effect from the next sample.

## Test plan
- Basic frame: H_PIX=8, V_LINES=4, threshold=10, a single pixel with diff=11 at (3,2) and all others 0 -> frame_done once, motion_count=1, box (3,3,2,2), bbox_valid=1; with min_count=1, motion_detected=1.
- Threshold boundary: diff=10 with threshold=10 -> not motion, count 0, bbox_valid=0, all box outputs 0. With threshold=31 and every pixel 31 -> count 0.
- Full frame: every pixel diff=31, threshold=0 -> count=32, box (0,7,0,3). With min_count=33 -> motion_detected=0.
- Early sync: vtcvsync asserted mid-line 2 -> frame_err pulse, no frame_done, previous results held. The following complete frame reports correctly.
- Overlong line: vtcvde high for 10 cycles on a line with H_PIX=8, motion at x=9 -> pixel ignored, x_max <= 7.
- Async reset: reset=0 mid-frame between clock edges -> outputs 0 immediately. After release, nothing reports until a vtcvsync followed by a full frame.
